// File: rtl/pcimid_pkg.sv
// Shared constants and helpers for the fetch/decode pipeline slice.
// Word width, the NOP encoding and the opcode/funct fields used by downstream stages.
package pcimid_pkg;
    localparam int          WORD_W    = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [5:0]  OP_RTYPE  = 6'h00;
    localparam logic [5:0]  OP_LW     = 6'h23;
    localparam logic [5:0]  OP_SW     = 6'h2b;
    localparam logic [5:0]  FN_ADD    = 6'h20;
    localparam logic [5:0]  FN_SUB    = 6'h22;
    localparam logic [5:0]  FN_AND    = 6'h24;
    localparam logic [5:0]  FN_OR     = 6'h25;
    localparam logic [5:0]  FN_SLT    = 6'h2a;

    // Clears the two byte-offset bits so every fetch address is word aligned.
    function automatic logic [WORD_W-1:0] align_word(input logic [WORD_W-1:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction
endpackage

// File: rtl/if_stage_instr_mem.sv
// Instruction memory: DEPTH x 32 array, synchronous write, asynchronous read.
// Contents are not reset; a same-cycle read of the written word returns the old value.
module instr_mem
    import pcimid_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_data
);
    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register, stall, flush and redirect.
// Optional IF_STALL_CNT_EN adds a saturating stall-cycle counter on stall_cnt_o.
module if_stage
    import pcimid_pkg::*;
#(
    parameter int          IMEM_DEPTH = 64,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          stall_i,
    input  logic                          flush_i,
    input  logic                          branch_taken_i,
    input  logic [31:0]                   branch_target_i,
    input  logic                          imem_wr_en_i,
    input  logic [$clog2(IMEM_DEPTH)-1:0] imem_wr_addr_i,
    input  logic [31:0]                   imem_wr_data_i,
`ifdef IF_STALL_CNT_EN
    output logic [15:0]                   stall_cnt_o,
`endif
    output logic [31:0]                   fetch_pc_o,
    output logic [31:0]                   instruction_o,
    output logic [31:0]                   pc_plus4_o,
    output logic                          valid_o
);
    localparam int ADDR_W = $clog2(IMEM_DEPTH);

    logic [31:0]       pc;
    logic [31:0]       pc_next_seq;
    logic [31:0]       fetched;
    logic [ADDR_W-1:0] rd_idx;

    // Upper PC bits are ignored, so fetches wrap modulo the memory depth.
    assign rd_idx      = pc[ADDR_W+1:2];
    assign pc_next_seq = pc + 32'd4;
    assign fetch_pc_o  = pc;

    instr_mem #(
        .DEPTH  (IMEM_DEPTH),
        .ADDR_W (ADDR_W)
    ) u_imem (
        .clk     (clk),
        .wr_en   (imem_wr_en_i),
        .wr_addr (imem_wr_addr_i),
        .wr_data (imem_wr_data_i),
        .rd_addr (rd_idx),
        .rd_data (fetched)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc            <= align_word(RESET_PC);
            instruction_o <= NOP_INSTR;
            pc_plus4_o    <= 32'd0;
            valid_o       <= 1'b0;
        end else if (branch_taken_i) begin
            pc            <= align_word(branch_target_i);
            instruction_o <= NOP_INSTR;
            pc_plus4_o    <= 32'd0;
            valid_o       <= 1'b0;
        end else if (stall_i) begin
            pc            <= pc;
        end else if (flush_i) begin
            pc            <= pc_next_seq;
            instruction_o <= NOP_INSTR;
            pc_plus4_o    <= 32'd0;
            valid_o       <= 1'b0;
        end else begin
            pc            <= pc_next_seq;
            instruction_o <= fetched;
            pc_plus4_o    <= pc_next_seq;
            valid_o       <= 1'b1;
        end
    end

`ifdef IF_STALL_CNT_EN
    // A redirect wins over a stall, so those cycles are not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_o <= 16'd0;
        end else if (stall_i && !branch_taken_i && (stall_cnt_o != 16'hFFFF)) begin
            stall_cnt_o <= stall_cnt_o + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus randomized traffic
// checked against a cycle-level reference model of the fetch rules.
module tb_if_stage;
    localparam int DEPTH = 64;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          stall_i, flush_i, branch_taken_i;
    logic [31:0]   branch_target_i;
    logic          imem_wr_en_i;
    logic [AW-1:0] imem_wr_addr_i;
    logic [31:0]   imem_wr_data_i;
    logic [31:0]   fetch_pc_o, instruction_o, pc_plus4_o;
    logic          valid_o;
`ifdef IF_STALL_CNT_EN
    logic [15:0]   stall_cnt_o;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid;
    int          m_cnt;

    always #5 clk = ~clk;

    if_stage #(.IMEM_DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall_i         (stall_i),
        .flush_i         (flush_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .imem_wr_en_i    (imem_wr_en_i),
        .imem_wr_addr_i  (imem_wr_addr_i),
        .imem_wr_data_i  (imem_wr_data_i),
`ifdef IF_STALL_CNT_EN
        .stall_cnt_o     (stall_cnt_o),
`endif
        .fetch_pc_o      (fetch_pc_o),
        .instruction_o   (instruction_o),
        .pc_plus4_o      (pc_plus4_o),
        .valid_o         (valid_o)
    );

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_cnt = 0;
    endtask

    // One clock: advance the model by the priority rules, then sample 1 time unit later.
    task automatic step();
        logic [31:0] word;
        @(posedge clk);
        word = m_mem[(m_pc / 4) % DEPTH];
        if (!rst_n) begin
            model_reset();
        end else if (branch_taken_i) begin
            m_pc = (branch_target_i / 4) * 4;
            m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        end else if (stall_i) begin
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
        end else if (flush_i) begin
            m_pc = m_pc + 32'd4;
            m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        end else begin
            m_instr = word;
            m_pc = m_pc + 32'd4;
            m_pc4 = m_pc;
            m_valid = 1'b1;
        end
        if (rst_n && imem_wr_en_i) m_mem[imem_wr_addr_i] = imem_wr_data_i;
        #1;
    endtask

    task automatic idle_inputs();
        stall_i = 0; flush_i = 0; branch_taken_i = 0; branch_target_i = 0;
        imem_wr_en_i = 0; imem_wr_addr_i = 0; imem_wr_data_i = 0;
    endtask

    task automatic redirect(input logic [31:0] target);
        branch_taken_i = 1; branch_target_i = target;
        step();
        branch_taken_i = 0; branch_target_i = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        model_reset();
        #3;
        tests_run++;
        if (fetch_pc_o !== 32'h0 || instruction_o !== 32'h0 || pc_plus4_o !== 32'h0 || valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset: pc=%h instr=%h pc4=%h valid=%b, required 0/0/0/0",
                     fetch_pc_o, instruction_o, pc_plus4_o, valid_o);
        end
`ifdef IF_STALL_CNT_EN
        tests_run++;
        if (stall_cnt_o !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_cnt: got %0d required 0", stall_cnt_o);
        end
`endif
    endtask

    task automatic test_preload();
        logic [31:0] prog [3];
        prog[0] = 32'h8C050014; prog[1] = 32'h00AA5820; prog[2] = 32'hAC0B0000;
        imem_wr_en_i = 1;
        for (int i = 0; i < DEPTH; i++) begin
            imem_wr_addr_i = AW'(i);
            imem_wr_data_i = (i < 3) ? prog[i] : $urandom;
            m_mem[i] = imem_wr_data_i;
            step();
        end
        imem_wr_en_i = 0;
    endtask

    task automatic test_fetch();
        logic [31:0] exp_w [3];
        exp_w[0] = 32'h8C050014; exp_w[1] = 32'h00AA5820; exp_w[2] = 32'hAC0B0000;
        rst_n = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            tests_run++;
            if (instruction_o !== exp_w[k] || pc_plus4_o !== 32'(4 * (k + 1)) || valid_o !== 1'b1) begin
                tests_failed++;
                $display("FAIL fetch%0d: instr=%h pc4=%0d valid=%b, required %h/%0d/1",
                         k, instruction_o, pc_plus4_o, valid_o, exp_w[k], 4 * (k + 1));
            end
        end
    endtask

    task automatic test_stall();
        int cnt0;
        redirect(32'h4);
        step();
`ifdef IF_STALL_CNT_EN
        cnt0 = int'(stall_cnt_o);
`else
        cnt0 = 0;
`endif
        stall_i = 1;
        flush_i = 1;
        for (int k = 0; k < 2; k++) begin
            step();
            tests_run++;
            if (instruction_o !== 32'h00AA5820 || pc_plus4_o !== 32'd8 || fetch_pc_o !== 32'd8 || valid_o !== 1'b1) begin
                tests_failed++;
                $display("FAIL stall%0d: instr=%h pc4=%0d pc=%0d valid=%b, required 00aa5820/8/8/1",
                         k, instruction_o, pc_plus4_o, fetch_pc_o, valid_o);
            end
        end
        flush_i = 0;
`ifdef IF_STALL_CNT_EN
        tests_run++;
        if (int'(stall_cnt_o) !== cnt0 + 2) begin
            tests_failed++;
            $display("FAIL stall_cnt: got %0d required %0d", stall_cnt_o, cnt0 + 2);
        end
`else
        if (cnt0 != 0) $display("[TB] unexpected counter base");
`endif
    endtask

    task automatic test_branch_over_stall();
        stall_i = 1;
        redirect(32'h6);
        stall_i = 0;
        tests_run++;
        if (fetch_pc_o !== 32'd4 || valid_o !== 1'b0 || instruction_o !== 32'h0 || pc_plus4_o !== 32'h0) begin
            tests_failed++;
            $display("FAIL branch_stall: pc=%0d valid=%b instr=%h pc4=%0d, required 4/0/0/0",
                     fetch_pc_o, valid_o, instruction_o, pc_plus4_o);
        end
`ifdef IF_STALL_CNT_EN
        tests_run++;
        if (int'(stall_cnt_o) !== m_cnt) begin
            tests_failed++;
            $display("FAIL branch_cnt: got %0d required %0d", stall_cnt_o, m_cnt);
        end
`endif
        step();
        tests_run++;
        if (instruction_o !== 32'h00AA5820 || pc_plus4_o !== 32'd8 || valid_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL branch_next: instr=%h pc4=%0d valid=%b, required 00aa5820/8/1",
                     instruction_o, pc_plus4_o, valid_o);
        end
    endtask

    task automatic test_flush();
        redirect(32'h0);
        flush_i = 1;
        step();
        flush_i = 0;
        tests_run++;
        if (valid_o !== 1'b0 || fetch_pc_o !== 32'd4 || instruction_o !== 32'h0) begin
            tests_failed++;
            $display("FAIL flush: valid=%b pc=%0d instr=%h, required 0/4/0", valid_o, fetch_pc_o, instruction_o);
        end
        step();
        tests_run++;
        if (instruction_o !== 32'h00AA5820 || valid_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_next: instr=%h valid=%b, required 00aa5820/1", instruction_o, valid_o);
        end
    endtask

    task automatic test_wrap();
        redirect(32'd256);
        step();
        tests_run++;
        if (instruction_o !== 32'h8C050014 || pc_plus4_o !== 32'd260) begin
            tests_failed++;
            $display("FAIL idx_wrap: instr=%h pc4=%0d, required 8c050014/260", instruction_o, pc_plus4_o);
        end
        redirect(32'hFFFF_FFFE);
        tests_run++;
        if (fetch_pc_o !== 32'hFFFF_FFFC) begin
            tests_failed++;
            $display("FAIL align: pc=%h required fffffffc", fetch_pc_o);
        end
        step();
        tests_run++;
        if (pc_plus4_o !== 32'h0 || fetch_pc_o !== 32'h0 || instruction_o !== m_mem[DEPTH-1] || valid_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL pc_wrap: pc4=%h pc=%h instr=%h valid=%b, required 0/0/%h/1",
                     pc_plus4_o, fetch_pc_o, instruction_o, m_mem[DEPTH-1], valid_o);
        end
    endtask

    task automatic test_write_during_read();
        // Overwrite the word currently being fetched; the old word must still be registered.
        imem_wr_en_i = 1;
        imem_wr_addr_i = fetch_pc_o[AW+1:2];
        imem_wr_data_i = 32'hDEAD_BEEF;
        step();
        imem_wr_en_i = 0;
        tests_run++;
        if (instruction_o !== m_instr || instruction_o === 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL wr_rd_same: instr=%h required %h (old word)", instruction_o, m_instr);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            stall_i        = ($urandom_range(0, 3) == 0);
            flush_i        = ($urandom_range(0, 5) == 0);
            branch_taken_i = ($urandom_range(0, 9) == 0);
            branch_target_i = $urandom;
            imem_wr_en_i   = ($urandom_range(0, 7) == 0);
            imem_wr_addr_i = AW'($urandom_range(0, DEPTH - 1));
            imem_wr_data_i = $urandom;
            step();
            tests_run++;
            if (fetch_pc_o !== m_pc || instruction_o !== m_instr || pc_plus4_o !== m_pc4 || valid_o !== m_valid
`ifdef IF_STALL_CNT_EN
                || int'(stall_cnt_o) !== m_cnt
`endif
            ) begin
                tests_failed++;
                $display("FAIL random%0d: pc=%h instr=%h pc4=%h valid=%b, required %h/%h/%h/%b",
                         n, fetch_pc_o, instruction_o, pc_plus4_o, valid_o, m_pc, m_instr, m_pc4, m_valid);
            end
        end
        idle_inputs();
    endtask

    task automatic test_mid_reset();
        step();
        step();
        rst_n = 0;
        #2;
        tests_run++;
        if (fetch_pc_o !== 32'h0 || valid_o !== 1'b0 || instruction_o !== 32'h0 || pc_plus4_o !== 32'h0) begin
            tests_failed++;
            $display("FAIL mid_reset: pc=%h valid=%b instr=%h pc4=%h, required all 0",
                     fetch_pc_o, valid_o, instruction_o, pc_plus4_o);
        end
        model_reset();
    endtask

    initial begin
        test_reset();
        test_preload();
        test_fetch();
        test_stall();
        test_branch_over_stall();
        test_flush();
        test_wrap();
        test_write_during_read();
        test_random();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
